// File: rtl/rect_compositor_pkg.sv
// Shared constants and the per-axis bounce step for the rectangle compositor.
// Optional feature macro used by the top: RECT_COLLIDE_EN.
package rect_compositor_pkg;

    localparam int RECT_POS_W = 12;
    localparam int RECT_IDX_W = 4;
    localparam int RECT_HIT_W = 13;
    localparam logic [RECT_IDX_W-1:0] RECT_NONE = 4'hF;

    // Colour is packed {r,g,b}; blue sits at bit 0.
    function automatic int rgb_g_off(input int bw);
        return bw;
    endfunction

    function automatic int rgb_r_off(input int gw, input int bw);
        return gw + bw;
    endfunction

    // One animation step on one axis. Returns {new_dir, new_pos}.
    // An axis whose rectangle cannot fit a full step inside the screen stays frozen.
    function automatic logic [RECT_POS_W:0] bounce_step(
        input logic [RECT_POS_W-1:0] pos,
        input logic [RECT_POS_W-1:0] half,
        input logic                  dir,
        input int                    speed,
        input int                    res
    );
        logic [RECT_POS_W+1:0] p;
        logic [RECT_POS_W+1:0] h;
        logic [RECT_POS_W+1:0] s;
        logic [RECT_POS_W+1:0] r;
        logic [RECT_POS_W:0]   nxt;
        p   = {2'b00, pos};
        h   = {2'b00, half};
        s   = (RECT_POS_W+2)'(speed);
        r   = (RECT_POS_W+2)'(res);
        nxt = {dir, pos};
        if ((h << 1) + (s << 1) >= r) begin
            nxt = {dir, pos};
        end else if (dir) begin
            if (p + h + s > r - 1'b1) nxt = {1'b0, pos - s[RECT_POS_W-1:0]};
            else                      nxt = {1'b1, pos + s[RECT_POS_W-1:0]};
        end else begin
            if (p < h + s) nxt = {1'b1, pos + s[RECT_POS_W-1:0]};
            else           nxt = {1'b0, pos - s[RECT_POS_W-1:0]};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rect_compositor_if.sv
// Configuration write bus for the rectangle compositor.
// wr_en is a single-cycle strobe with no ready: every strobe is accepted on the
// clock edge it is seen, and all other fields are only meaningful while wr_en=1.
interface rect_compositor_if #(parameter int RGB_W = 8);
    import rect_compositor_pkg::*;

    logic                  wr_en;
    logic [RECT_IDX_W-1:0] wr_idx;
    logic [RECT_POS_W-1:0] wr_cx;
    logic [RECT_POS_W-1:0] wr_cy;
    logic [RECT_POS_W-1:0] wr_hw;
    logic [RECT_POS_W-1:0] wr_hh;
    logic [RGB_W-1:0]      wr_rgb;
    logic [1:0]            wr_dir;
    logic                  wr_vis;

    modport master (output wr_en, wr_idx, wr_cx, wr_cy, wr_hw, wr_hh, wr_rgb, wr_dir, wr_vis);
    modport slave  (input  wr_en, wr_idx, wr_cx, wr_cy, wr_hw, wr_hh, wr_rgb, wr_dir, wr_vis);

endinterface

// File: rtl/rect_compositor_mover.sv
// rect_mover: one rectangle's registers plus its bounce animation.
// A config write in the same cycle as an animate strobe wins; no step is applied.
module rect_mover import rect_compositor_pkg::*; #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int SPEED = 1,
    parameter int RGB_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    input  logic                  i_animate,
    input  logic                  i_wr,
    input  logic [RECT_POS_W-1:0] i_cx,
    input  logic [RECT_POS_W-1:0] i_cy,
    input  logic [RECT_POS_W-1:0] i_hw,
    input  logic [RECT_POS_W-1:0] i_hh,
    input  logic [RGB_W-1:0]      i_rgb,
    input  logic [1:0]            i_dir,
    input  logic                  i_vis,
    output logic [RECT_POS_W-1:0] o_cx,
    output logic [RECT_POS_W-1:0] o_cy,
    output logic [RECT_POS_W-1:0] o_hw,
    output logic [RECT_POS_W-1:0] o_hh,
    output logic [RGB_W-1:0]      o_rgb,
    output logic                  o_vis
);

    logic [RECT_POS_W-1:0] r_cx, r_cy, r_hw, r_hh;
    logic [RGB_W-1:0]      r_rgb;
    logic [1:0]            r_dir;
    logic                  r_vis;
    logic [RECT_POS_W:0]   w_step_x, w_step_y;

    assign w_step_x = bounce_step(r_cx, r_hw, r_dir[1], SPEED, H_RES);
    assign w_step_y = bounce_step(r_cy, r_hh, r_dir[0], SPEED, V_RES);

    // Rectangle state: config load has priority over the animation step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cx  <= '0;
            r_cy  <= '0;
            r_hw  <= '0;
            r_hh  <= '0;
            r_rgb <= '0;
            r_dir <= 2'b11;
            r_vis <= 1'b0;
        end else if (i_wr) begin
            r_cx  <= i_cx;
            r_cy  <= i_cy;
            r_hw  <= i_hw;
            r_hh  <= i_hh;
            r_rgb <= i_rgb;
            r_dir <= i_dir;
            r_vis <= i_vis;
        end else if (i_pix_stb && i_animate && r_vis) begin
            r_dir <= {w_step_x[RECT_POS_W], w_step_y[RECT_POS_W]};
            r_cx  <= w_step_x[RECT_POS_W-1:0];
            r_cy  <= w_step_y[RECT_POS_W-1:0];
        end
    end

    assign o_cx  = r_cx;
    assign o_cy  = r_cy;
    assign o_hw  = r_hw;
    assign o_hh  = r_hh;
    assign o_rgb = r_rgb;
    assign o_vis = r_vis;

endmodule

// File: rtl/rect_compositor.sv
// rect_compositor: N_RECT bouncing rectangles composited by fixed priority
// (index 0 on top). Two pixel-strobe pipeline; hs/vs delayed to match.
// Optional macro RECT_COLLIDE_EN adds the o_collide per-frame overlap report.
module rect_compositor import rect_compositor_pkg::*; #(
    parameter int N_RECT = 4,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int SPEED  = 1,
    parameter int RW     = 2,
    parameter int GW     = 3,
    parameter int BW     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    input  logic                  i_animate,
    input  logic [9:0]            i_x,
    input  logic [8:0]            i_y,
    input  logic                  i_hs,
    input  logic                  i_vs,
    rect_compositor_if.slave      cfg,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic [RW-1:0]         o_r,
    output logic [GW-1:0]         o_g,
    output logic [BW-1:0]         o_b,
    output logic [RECT_IDX_W-1:0] o_hit_id
`ifdef RECT_COLLIDE_EN
    ,
    output logic [N_RECT-1:0]     o_collide
`endif
);

    localparam int RGB_W = RW + GW + BW;
    localparam int G_OFF = rgb_g_off(BW);
    localparam int R_OFF = rgb_r_off(GW, BW);

    logic [RECT_POS_W-1:0] w_cx [N_RECT];
    logic [RECT_POS_W-1:0] w_cy [N_RECT];
    logic [RECT_POS_W-1:0] w_hw [N_RECT];
    logic [RECT_POS_W-1:0] w_hh [N_RECT];
    logic [RGB_W-1:0]      w_rgb [N_RECT];
    logic [N_RECT-1:0]     w_vis, w_wr, w_hit;

    logic [N_RECT-1:0]     r_hit;
    logic                  r_hs1, r_vs1, r_hs2, r_vs2;
    logic [RGB_W-1:0]      r_rgb;
    logic [RECT_IDX_W-1:0] r_id;
    logic [RGB_W-1:0]      w_win_rgb;
    logic [RECT_IDX_W-1:0] w_win_id;

    for (genvar g = 0; g < N_RECT; g++) begin : g_rect
        // Indices at or above N_RECT never match, so those writes fall away.
        assign w_wr[g] = cfg.wr_en && (cfg.wr_idx == RECT_IDX_W'(g));

        rect_mover #(
            .H_RES (H_RES),
            .V_RES (V_RES),
            .SPEED (SPEED),
            .RGB_W (RGB_W)
        ) u_mover (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_pix_stb (i_pix_stb),
            .i_animate (i_animate),
            .i_wr      (w_wr[g]),
            .i_cx      (cfg.wr_cx),
            .i_cy      (cfg.wr_cy),
            .i_hw      (cfg.wr_hw),
            .i_hh      (cfg.wr_hh),
            .i_rgb     (cfg.wr_rgb),
            .i_dir     (cfg.wr_dir),
            .i_vis     (cfg.wr_vis),
            .o_cx      (w_cx[g]),
            .o_cy      (w_cy[g]),
            .o_hw      (w_hw[g]),
            .o_hh      (w_hh[g]),
            .o_rgb     (w_rgb[g]),
            .o_vis     (w_vis[g])
        );

        // Widened compare so cx-hw is never formed and cannot underflow.
        assign w_hit[g] = w_vis[g]
            && (RECT_HIT_W'(i_x) + RECT_HIT_W'(w_hw[g]) > RECT_HIT_W'(w_cx[g]))
            && (RECT_HIT_W'(i_x) < RECT_HIT_W'(w_cx[g]) + RECT_HIT_W'(w_hw[g]))
            && (RECT_HIT_W'(i_y) + RECT_HIT_W'(w_hh[g]) > RECT_HIT_W'(w_cy[g]))
            && (RECT_HIT_W'(i_y) < RECT_HIT_W'(w_cy[g]) + RECT_HIT_W'(w_hh[g]));
    end

    // Stage 1: capture the hit vector and syncs for this pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit <= '0;
            r_hs1 <= 1'b1;
            r_vs1 <= 1'b1;
        end else if (i_pix_stb) begin
            r_hit <= w_hit;
            r_hs1 <= i_hs;
            r_vs1 <= i_vs;
        end
    end

    // Priority select: scan high to low so the lowest set index is left standing.
    always_comb begin
        w_win_id  = RECT_NONE;
        w_win_rgb = '0;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (r_hit[i]) begin
                w_win_id  = RECT_IDX_W'(i);
                w_win_rgb = w_rgb[i];
            end
        end
    end

    // Stage 2: register the composited colour, winner id and delayed syncs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rgb <= '0;
            r_id  <= RECT_NONE;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
        end else if (i_pix_stb) begin
            r_rgb <= w_win_rgb;
            r_id  <= w_win_id;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
        end
    end

    assign o_r      = r_rgb[R_OFF +: RW];
    assign o_g      = r_rgb[G_OFF +: GW];
    assign o_b      = r_rgb[0 +: BW];
    assign o_hit_id = r_id;
    assign o_hs     = r_hs2;
    assign o_vs     = r_vs2;

`ifdef RECT_COLLIDE_EN
    logic [N_RECT-1:0] r_flags, r_collide, w_coll;

    // A rect collides when it and at least one other rect hit the same pixel.
    always_comb begin
        w_coll = '0;
        for (int i = 0; i < N_RECT; i++) begin
            w_coll[i] = r_hit[i] && ((r_hit & ~(N_RECT'(1) << i)) != '0);
        end
    end

    // Sticky per-frame flags, published and cleared on the end-of-frame pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags   <= '0;
            r_collide <= '0;
        end else if (i_pix_stb) begin
            if (i_animate) begin
                r_collide <= r_flags;
                r_flags   <= '0;
            end else begin
                r_flags   <= r_flags | w_coll;
            end
        end
    end

    assign o_collide = r_collide;
`endif

endmodule

// File: tb/tb_rect_compositor.sv
// Directed bench for rect_compositor (N_RECT=4, 640x480, SPEED=1, RGB 2/3/3).
module tb_rect_compositor;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_pix_stb = 1'b0;
  logic       i_animate = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;
  logic       i_hs = 1'b1;
  logic       i_vs = 1'b1;
  logic       o_hs, o_vs;
  logic [1:0] o_r;
  logic [2:0] o_g;
  logic [2:0] o_b;
  logic [3:0] o_hit_id;
`ifdef RECT_COLLIDE_EN
  logic [3:0] o_collide;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] RED   = 8'b11_000_000;
  localparam logic [7:0] GREEN = 8'b00_111_000;
  localparam logic [7:0] BLUE  = 8'b00_000_111;

  rect_compositor_if #(.RGB_W(8)) cfg ();

  rect_compositor dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pix_stb (i_pix_stb),
    .i_animate (i_animate),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_hs      (i_hs),
    .i_vs      (i_vs),
    .cfg       (cfg),
    .o_hs      (o_hs),
    .o_vs      (o_vs),
    .o_r       (o_r),
    .o_g       (o_g),
    .o_b       (o_b),
    .o_hit_id  (o_hit_id)
`ifdef RECT_COLLIDE_EN
    ,
    .o_collide (o_collide)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- driver tasks ----------------
  task automatic write_rect(input int idx, input int cx, input int cy, input int hw, input int hh,
                            input logic [7:0] rgb, input logic [1:0] dir, input logic vis);
    cfg.wr_idx = 4'(idx);
    cfg.wr_cx  = 12'(cx);
    cfg.wr_cy  = 12'(cy);
    cfg.wr_hw  = 12'(hw);
    cfg.wr_hh  = 12'(hh);
    cfg.wr_rgb = rgb;
    cfg.wr_dir = dir;
    cfg.wr_vis = vis;
    cfg.wr_en  = 1'b1;
    @(posedge i_clk);
    #1;
    cfg.wr_en  = 1'b0;
  endtask

  // One pixel strobe followed by three idle clocks (25 MHz in a 100 MHz domain).
  task automatic strobe(input int x, input int y, input logic hs, input logic vs, input logic anim);
    i_x = 10'(x);
    i_y = 9'(y);
    i_hs = hs;
    i_vs = vs;
    i_animate = anim;
    i_pix_stb = 1'b1;
    @(posedge i_clk);
    #1;
    i_pix_stb = 1'b0;
    i_animate = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  // Present (x,y), then one more strobe: the result of (x,y) is then on the outputs.
  task automatic probe(input int x, input int y, output logic [3:0] id, output logic [7:0] rgb);
    strobe(x, y, 1'b1, 1'b1, 1'b0);
    strobe(0, 0, 1'b1, 1'b1, 1'b0);
    id  = o_hit_id;
    rgb = {o_r, o_g, o_b};
  endtask

  task automatic hide_all();
    for (int i = 0; i < 4; i++) write_rect(i, 0, 0, 0, 0, 8'h00, 2'b11, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_hit_id, o_r, o_g, o_b} !== {4'hF, 8'h00}) begin
      errors++;
      $display("FAIL reset_colour got id=%h rgb=%h want id=f rgb=00", o_hit_id, {o_r, o_g, o_b});
    end
    checks++;
    if ({o_hs, o_vs} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync got hs/vs=%b%b want 11", o_hs, o_vs);
    end
`ifdef RECT_COLLIDE_EN
    checks++;
    if (o_collide !== 4'b0000) begin
      errors++;
      $display("FAIL reset_collide got %b want 0000", o_collide);
    end
`endif
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  // Horizontal sweep across a 19x19 red square at (100,100); every output is
  // checked against the pixel presented one strobe earlier than the one just sent.
  task automatic test_pixel_window();
    logic [13:0] exp_q[$];
    logic [13:0] want, got;
    logic [3:0]  id;
    logic [7:0]  rgb;
    int          ys[4];
    logic [3:0]  yid[4];
    logic        hs, vs;
    write_rect(0, 100, 100, 10, 10, RED, 2'b11, 1'b1);
    strobe(0, 0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({4'hF, 8'h00, 2'b11});
    for (int x = 88; x <= 112; x++) begin
      hs = (x % 3) != 0;
      vs = (x % 4) != 0;
      if (x >= 91 && x <= 109) exp_q.push_back({4'h0, RED, hs, vs});
      else                     exp_q.push_back({4'hF, 8'h00, hs, vs});
      strobe(x, 100, hs, vs, 1'b0);
      want = exp_q.pop_front();
      got  = {o_hit_id, o_r, o_g, o_b, o_hs, o_vs};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pixel_sweep x=%0d got {id,rgb,hs,vs}=%h want %h", x - 1, got, want);
      end
    end
    strobe(0, 0, 1'b1, 1'b1, 1'b0);
    want = exp_q.pop_front();
    got  = {o_hit_id, o_r, o_g, o_b, o_hs, o_vs};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pixel_sweep_tail got %h want %h", got, want);
    end
    ys  = '{90, 91, 109, 110};
    yid = '{4'hF, 4'h0, 4'h0, 4'hF};
    for (int k = 0; k < 4; k++) begin
      probe(100, ys[k], id, rgb);
      checks++;
      if (id !== yid[k] || rgb !== ((yid[k] == 4'h0) ? RED : 8'h00)) begin
        errors++;
        $display("FAIL pixel_y y=%0d got id=%h rgb=%h want id=%h", ys[k], id, rgb, yid[k]);
      end
    end
    hide_all();
  endtask

  task automatic test_priority();
    logic [3:0] id;
    logic [7:0] rgb;
    write_rect(0, 200, 200, 10, 10, RED, 2'b11, 1'b1);
    write_rect(1, 205, 205, 20, 20, GREEN, 2'b11, 1'b1);
    probe(200, 200, id, rgb);
    checks++;
    if (id !== 4'h0 || rgb !== RED) begin
      errors++;
      $display("FAIL prio_both got id=%h rgb=%h want id=0 rgb=%h", id, rgb, RED);
    end
    probe(224, 224, id, rgb);
    checks++;
    if (id !== 4'h1 || rgb !== GREEN) begin
      errors++;
      $display("FAIL prio_only1 got id=%h rgb=%h want id=1 rgb=%h", id, rgb, GREEN);
    end
    write_rect(0, 200, 200, 10, 10, RED, 2'b11, 1'b0);
    probe(200, 200, id, rgb);
    checks++;
    if (id !== 4'h1 || rgb !== GREEN) begin
      errors++;
      $display("FAIL prio_hidden0 got id=%h rgb=%h want id=1 rgb=%h", id, rgb, GREEN);
    end
    hide_all();
  endtask

  // op 0: probe (a,b) expect id c; op 1: animate strobe; op 2: write rect0 cx=a cy=b hw=c hh=d dir=e.
  typedef struct {
    int op;
    int a;
    int b;
    int c;
    int d;
    int e;
  } step_t;

  task automatic test_bounce();
    step_t      steps[$];
    logic [3:0] id;
    logic [7:0] rgb;
    steps = '{
      '{2, 628, 240, 10, 240, 3},
      '{1, 0, 0, 0, 0, 0},
      '{0, 620, 240, 0, 0, 0}, '{0, 619, 240, 15, 0, 0},
      '{0, 638, 240, 0, 0, 0}, '{0, 639, 240, 15, 0, 0},
      '{1, 0, 0, 0, 0, 0},
      '{0, 619, 240, 0, 0, 0}, '{0, 618, 240, 15, 0, 0},
      '{0, 637, 240, 0, 0, 0}, '{0, 638, 240, 15, 0, 0},
      '{1, 0, 0, 0, 0, 0},
      '{0, 618, 240, 0, 0, 0}, '{0, 617, 240, 15, 0, 0},
      '{2, 11, 240, 10, 240, 1},
      '{1, 0, 0, 0, 0, 0},
      '{0, 1, 240, 0, 0, 0}, '{0, 0, 240, 15, 0, 0},
      '{0, 19, 240, 0, 0, 0}, '{0, 20, 240, 15, 0, 0},
      '{1, 0, 0, 0, 0, 0},
      '{0, 2, 240, 0, 0, 0}, '{0, 1, 240, 15, 0, 0}, '{0, 20, 240, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0},
      '{0, 3, 240, 0, 0, 0}, '{0, 2, 240, 15, 0, 0}, '{0, 21, 240, 0, 0, 0},
      '{2, 320, 240, 320, 240, 3},
      '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0},
      '{0, 1, 240, 0, 0, 0}, '{0, 0, 240, 15, 0, 0}, '{0, 639, 240, 0, 0, 0},
      '{2, 320, 468, 320, 10, 3},
      '{1, 0, 0, 0, 0, 0},
      '{0, 100, 460, 0, 0, 0}, '{0, 100, 459, 15, 0, 0},
      '{0, 100, 478, 0, 0, 0}, '{0, 100, 479, 15, 0, 0},
      '{1, 0, 0, 0, 0, 0},
      '{0, 100, 459, 0, 0, 0}, '{0, 100, 478, 15, 0, 0}
    };
    foreach (steps[k]) begin
      case (steps[k].op)
        0: begin
          probe(steps[k].a, steps[k].b, id, rgb);
          checks++;
          if (id !== 4'(steps[k].c)) begin
            errors++;
            $display("FAIL bounce step=%0d x=%0d y=%0d got id=%h want %h",
                     k, steps[k].a, steps[k].b, id, 4'(steps[k].c));
          end
        end
        1: strobe(0, 0, 1'b1, 1'b1, 1'b1);
        default: write_rect(0, steps[k].a, steps[k].b, steps[k].c, steps[k].d, BLUE,
                            2'(steps[k].e), 1'b1);
      endcase
    end
    hide_all();
  endtask

  task automatic test_write_vs_animate();
    logic [3:0] id;
    logic [7:0] rgb;
    int         xs[4];
    logic [3:0] xid[4];
    write_rect(2, 300, 240, 10, 240, BLUE, 2'b11, 1'b1);
    // write and animate strobe in the very same clock
    cfg.wr_idx = 4'd2;
    cfg.wr_cx  = 12'd400;
    cfg.wr_cy  = 12'd240;
    cfg.wr_hw  = 12'd10;
    cfg.wr_hh  = 12'd240;
    cfg.wr_rgb = GREEN;
    cfg.wr_dir = 2'b11;
    cfg.wr_vis = 1'b1;
    cfg.wr_en  = 1'b1;
    i_x = '0;
    i_y = '0;
    i_animate = 1'b1;
    i_pix_stb = 1'b1;
    @(posedge i_clk);
    #1;
    cfg.wr_en = 1'b0;
    i_animate = 1'b0;
    i_pix_stb = 1'b0;
    xs  = '{391, 390, 409, 410};
    xid = '{4'h2, 4'hF, 4'h2, 4'hF};
    for (int k = 0; k < 4; k++) begin
      probe(xs[k], 240, id, rgb);
      checks++;
      if (id !== xid[k] || rgb !== ((xid[k] == 4'h2) ? GREEN : 8'h00)) begin
        errors++;
        $display("FAIL wr_anim x=%0d got id=%h rgb=%h want id=%h", xs[k], id, rgb, xid[k]);
      end
    end
    write_rect(4, 50, 240, 10, 240, RED, 2'b11, 1'b1);
    write_rect(15, 50, 240, 10, 240, RED, 2'b11, 1'b1);
    probe(50, 240, id, rgb);
    checks++;
    if (id !== 4'hF || rgb !== 8'h00) begin
      errors++;
      $display("FAIL wr_oob got id=%h rgb=%h want id=f rgb=00", id, rgb);
    end
    probe(400, 240, id, rgb);
    checks++;
    if (id !== 4'h2) begin
      errors++;
      $display("FAIL wr_oob_keep got id=%h want 2", id);
    end
    hide_all();
  endtask

`ifdef RECT_COLLIDE_EN
  task automatic test_collide();
    logic [3:0] id;
    logic [7:0] rgb;
    write_rect(0, 100, 100, 10, 10, RED, 2'b11, 1'b1);
    write_rect(1, 105, 105, 10, 10, GREEN, 2'b11, 1'b1);
    probe(103, 103, id, rgb);
    strobe(0, 0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (o_collide !== 4'b0011) begin
      errors++;
      $display("FAIL collide_set got %b want 0011", o_collide);
    end
    write_rect(1, 300, 300, 10, 10, GREEN, 2'b11, 1'b1);
    probe(103, 103, id, rgb);
    strobe(0, 0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (o_collide !== 4'b0000) begin
      errors++;
      $display("FAIL collide_clear got %b want 0000", o_collide);
    end
    hide_all();
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [3:0] id;
    logic [7:0] rgb;
    write_rect(0, 100, 100, 10, 10, RED, 2'b11, 1'b1);
    strobe(100, 100, 1'b0, 1'b0, 1'b0);
    strobe(100, 100, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_hit_id, o_r, o_g, o_b, o_hs, o_vs} !== {4'h0, RED, 2'b00}) begin
      errors++;
      $display("FAIL midrst_pre got {id,rgb,hs,vs}=%h want %h",
               {o_hit_id, o_r, o_g, o_b, o_hs, o_vs}, {4'h0, RED, 2'b00});
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_hit_id, o_r, o_g, o_b, o_hs, o_vs} !== {4'hF, 8'h00, 2'b11}) begin
      errors++;
      $display("FAIL midrst_async got {id,rgb,hs,vs}=%h want %h",
               {o_hit_id, o_r, o_g, o_b, o_hs, o_vs}, {4'hF, 8'h00, 2'b11});
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    probe(100, 100, id, rgb);
    checks++;
    if (id !== 4'hF || rgb !== 8'h00) begin
      errors++;
      $display("FAIL midrst_hidden got id=%h rgb=%h want id=f rgb=00", id, rgb);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cfg.wr_en  = 1'b0;
    cfg.wr_idx = '0;
    cfg.wr_cx  = '0;
    cfg.wr_cy  = '0;
    cfg.wr_hw  = '0;
    cfg.wr_hh  = '0;
    cfg.wr_rgb = '0;
    cfg.wr_dir = 2'b11;
    cfg.wr_vis = 1'b0;
    test_reset();
    test_pixel_window();
    test_priority();
    test_bounce();
    test_write_vs_animate();
`ifdef RECT_COLLIDE_EN
    test_collide();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
